// File: rtl/keypad_emulator.sv
// Device-side 3x4 keypad model: queued key codes are "pressed" for a programmed time,
// driving the key's row while the scanner drives its column. Optional contact bounce: KEYPAD_EMULATOR_BOUNCE_EN.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned RELEASE_CYCLES = 8,
  parameter int unsigned DEPTH_LOG2     = 2,
  parameter int unsigned BOUNCE_CYCLES  = 4
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [3:0] keyCode,
  input  logic       keyValid,
  output logic       keyReady,
  input  logic [2:0] activeColumn,
  output logic [3:0] activeRow,
  output logic       busy,
  output logic       keyDropped
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned PW      = DEPTH_LOG2 + 1;
  localparam int unsigned MAX_HR  = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_HR > BOUNCE_CYCLES) ? MAX_HR : BOUNCE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    , ST_BOUNCE = 2'd3
`endif
  } state_e;

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  // Bounce offset (BOUNCE_CYCLES-1-cnt) is even on closed cycles; compare LSB parity.
  localparam logic BOUNCE_PH = 1'((BOUNCE_CYCLES - 1) % 2);
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cur_key_q, cur_key_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [3:0]       row_q, row_d;
  logic             dropped_q, dropped_d;
  logic [3:0]       mem_q [DEPTH];

  logic       full, empty, accept, push, pop, contact;
  logic [3:0] head;
  logic [2:0] key_col;
  logic [3:0] key_row;

  always_comb begin
    full      = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    empty     = (wr_ptr_q == rd_ptr_q);
    accept    = keyValid && !full;
    push      = accept && (keyCode < 4'd12);
    dropped_d = accept && !(keyCode < 4'd12);
    head      = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_key_d = cur_key_q;
    pop       = 1'b0;
    contact   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          cur_key_d = head;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
          state_d   = ST_BOUNCE;
          cnt_d     = CNT_W'(BOUNCE_CYCLES - 1);
`else
          state_d   = ST_PRESS;
          cnt_d     = CNT_W'(HOLD_CYCLES - 1);
`endif
        end
      end
      ST_PRESS: begin
        contact = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RELEASE;
          cnt_d   = CNT_W'(RELEASE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!empty) begin
          pop       = 1'b1;
          cur_key_d = head;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
          state_d   = ST_BOUNCE;
          cnt_d     = CNT_W'(BOUNCE_CYCLES - 1);
`else
          state_d   = ST_PRESS;
          cnt_d     = CNT_W'(HOLD_CYCLES - 1);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
      ST_BOUNCE: begin
        contact = (cnt_q[0] == BOUNCE_PH);
        if (cnt_q == '0) begin
          state_d = ST_PRESS;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    key_col = '0;
    key_row = '0;
    case (cur_key_q)
      4'd1:  begin key_col = 3'b100; key_row = 4'b1000; end
      4'd2:  begin key_col = 3'b010; key_row = 4'b1000; end
      4'd3:  begin key_col = 3'b001; key_row = 4'b1000; end
      4'd4:  begin key_col = 3'b100; key_row = 4'b0100; end
      4'd5:  begin key_col = 3'b010; key_row = 4'b0100; end
      4'd6:  begin key_col = 3'b001; key_row = 4'b0100; end
      4'd7:  begin key_col = 3'b100; key_row = 4'b0010; end
      4'd8:  begin key_col = 3'b010; key_row = 4'b0010; end
      4'd9:  begin key_col = 3'b001; key_row = 4'b0010; end
      4'd10: begin key_col = 3'b100; key_row = 4'b0001; end
      4'd0:  begin key_col = 3'b010; key_row = 4'b0001; end
      4'd11: begin key_col = 3'b001; key_row = 4'b0001; end
      default: ;
    endcase
    row_d = (contact && ((activeColumn & key_col) != '0)) ? key_row : '0;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_key_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      row_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_key_q <= cur_key_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      row_q     <= row_d;
      dropped_q <= dropped_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= keyCode;
    end
  end

  assign keyReady   = !full;
  assign activeRow  = row_q;
  assign keyDropped = dropped_q;
  assign busy       = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: timeline model of key press windows, FIFO occupancy and drops,
// checked every cycle, plus literal expectations from the key-entry scenarios.
module tb_keypad_emulator;

  localparam int H     = 16;
  localparam int R     = 8;
  localparam int DL    = 2;
  localparam int DEPTH = 4;
  localparam int BCFG  = 4;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  localparam int B = BCFG;
`else
  localparam int B = 0;
`endif
  localparam int P = B + H + R;

  logic       clock, resetN, keyValid, keyReady, busy, keyDropped;
  logic [3:0] keyCode, activeRow;
  logic [2:0] activeColumn;

  keypad_emulator #(
    .HOLD_CYCLES(H), .RELEASE_CYCLES(R), .DEPTH_LOG2(DL), .BOUNCE_CYCLES(BCFG)
  ) dut (
    .clock(clock), .resetN(resetN), .keyCode(keyCode), .keyValid(keyValid),
    .keyReady(keyReady), .activeColumn(activeColumn), .activeRow(activeRow),
    .busy(busy), .keyDropped(keyDropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Each accepted key: code, acceptance cycle, first cycle of its key time.
  typedef struct { int code; int t; int s; } key_t;
  key_t       kq[$];
  int         last_end, cyc, n_acc, checks, fails;
  logic [2:0] col_hist [0:8191];
  bit         drop_hist [0:8191];
  bit         rotate;

  function automatic logic [2:0] col_mask(input int k);
    if (k == 0)  return 3'b010;
    if (k == 10) return 3'b100;
    if (k == 11) return 3'b001;
    return 3'b001 << (2 - (k - 1) % 3);
  endfunction

  function automatic logic [3:0] row_of(input int k);
    if (k >= 1 && k <= 9) return 4'b0001 << (3 - (k - 1) / 3);
    return 4'b0001;
  endfunction

  function automatic bit closed(input int j);
    return (j >= 0 && j < B && j % 2 == 0) || (j >= B && j < B + H);
  endfunction

  function automatic logic [3:0] exp_row(input int c);
    logic [3:0] r;
    r = 4'b0000;
    if (c < 1) return r;
    foreach (kq[i])
      if (closed(c - 1 - kq[i].s) && ((col_hist[c-1] & col_mask(kq[i].code)) != 3'b000))
        r = row_of(kq[i].code);
    return r;
  endfunction

  function automatic bit exp_busy(input int c);
    foreach (kq[i]) if (kq[i].t + 1 <= c && c < kq[i].s + P) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_ready(input int c);
    int n;
    n = 0;
    foreach (kq[i]) if (kq[i].t + 1 <= c && c <= kq[i].s - 1) n++;
    return n < DEPTH;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Ends the current cycle (updating the model from the sampled inputs), then compares mid-cycle.
  task automatic tick();
    key_t k;
    @(posedge clock);
    col_hist[cyc]  = activeColumn;
    drop_hist[cyc] = 1'b0;
    if (resetN && keyValid && exp_ready(cyc)) begin
      n_acc++;
      if (keyCode < 4'd12) begin
        k.code   = int'(keyCode);
        k.t      = cyc;
        k.s      = (cyc + 2 > last_end) ? cyc + 2 : last_end;
        last_end = k.s + P;
        kq.push_back(k);
      end else begin
        drop_hist[cyc] = 1'b1;
      end
    end
    cyc++;
    @(negedge clock);
    chk("activeRow",  activeRow,            exp_row(cyc));
    chk("busy",       {3'b000, busy},       {3'b000, exp_busy(cyc)});
    chk("keyReady",   {3'b000, keyReady},   {3'b000, exp_ready(cyc)});
    chk("keyDropped", {3'b000, keyDropped}, {3'b000, drop_hist[cyc-1] && resetN});
    if (rotate) activeColumn = 3'b001 << (cyc % 3);
  endtask

  task automatic run_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input logic [3:0] code, input int maxw, output int t);
    int n0;
    n0 = n_acc;
    t = -1;
    keyCode = code;
    keyValid = 1'b1;
    for (int i = 0; i < maxw; i++) begin
      tick();
      if (n_acc != n0) begin
        t = cyc - 1;
        break;
      end
    end
    keyValid = 1'b0;
    checks++;
    if (t < 0) begin
      fails++;
      $display("FAIL push_timeout code %0d: got no accept expected accept within %0d cycles", code, maxw);
    end
  endtask

  initial begin
    int t, t0, t1, t5;
    resetN = 1'b0; keyValid = 1'b0; keyCode = 4'd0; activeColumn = 3'b000;
    cyc = 0; n_acc = 0; checks = 0; fails = 0; last_end = 0; rotate = 1'b0;

    repeat (3) tick();
    chk("reset_row",   activeRow, 4'b0000);
    chk("reset_ready", {3'b000, keyReady}, 4'b0001);
    chk("reset_busy",  {3'b000, busy}, 4'b0000);
    #2 resetN = 1'b1;
    tick();

    // Key 5 with col2 held.
    activeColumn = 3'b010;
    push(4'd5, 5, t);
    run_until(t + 2);
    chk("k5_before", activeRow, 4'b0000);
    run_until(t + 3);
    chk("k5_first", activeRow, 4'b0100);
    run_until(t + 3 + B);
    chk("k5_hold_start", activeRow, 4'b0100);
    run_until(t + 2 + B + H);
    chk("k5_hold_end", activeRow, 4'b0100);
    run_until(t + 3 + B + H);
    chk("k5_released", activeRow, 4'b0000);
    run_until(t + 1 + P);
    chk("k5_busy_last", {3'b000, busy}, 4'b0001);
    run_until(t + 2 + P);
    chk("k5_busy_done", {3'b000, busy}, 4'b0000);

    // Keys 1, 2, #, * back-to-back with rotating column drive.
    rotate = 1'b1;
    push(4'd1, 5, t1);
    push(4'd2, 5, t);
    push(4'd11, 5, t);
    push(4'd10, 5, t);
    for (int j = B + H + 1; j <= P; j++) begin
      run_until(t1 + 2 + j);
      chk("gap_1_2", activeRow, 4'b0000);
    end
    run_until(last_end + 2);
    rotate = 1'b0;

    // FIFO fill: first key pops, four more fill the FIFO, fifth is held off.
    activeColumn = 3'b111;
    push(4'd5, 5, t0);
    push(4'd3, 5, t);
    push(4'd6, 5, t);
    push(4'd9, 5, t);
    push(4'd0, 5, t);
    chk("fifo_full_ready", {3'b000, keyReady}, 4'b0000);
    push(4'd7, 60, t5);
    checks++;
    if (t5 != t0 + 2 + P) begin
      fails++;
      $display("FAIL fifth_accept_cycle: got %0d expected %0d", t5, t0 + 2 + P);
    end
    run_until(last_end + 2);
    chk("fifo_drained", {3'b000, busy}, 4'b0000);

    // Invalid code is dropped.
    push(4'd13, 5, t);
    chk("drop_pulse", {3'b000, keyDropped}, 4'b0001);
    chk("drop_busy",  {3'b000, busy}, 4'b0000);
    tick();
    chk("drop_end",   {3'b000, keyDropped}, 4'b0000);
    chk("drop_row",   activeRow, 4'b0000);

    // Reset during key 9 press with a second key queued.
    activeColumn = 3'b001;
    push(4'd9, 5, t);
    push(4'd4, 5, t1);
    run_until(t + 3 + B + 2);
    chk("k9_pressed", activeRow, 4'b0010);
    #2 resetN = 1'b0;
    #1;
    chk("async_row",   activeRow, 4'b0000);
    chk("async_busy",  {3'b000, busy}, 4'b0000);
    chk("async_ready", {3'b000, keyReady}, 4'b0001);
    kq.delete();
    last_end = 0;
    repeat (3) tick();
    #2 resetN = 1'b1;
    repeat (30) tick();
    chk("post_reset_busy", {3'b000, busy}, 4'b0000);
    chk("post_reset_row",  activeRow, 4'b0000);

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    // Bounce pattern on key 0 with col2 driven.
    activeColumn = 3'b010;
    push(4'd0, 5, t);
    run_until(t + 3); chk("bounce_0", activeRow, 4'b0001);
    run_until(t + 4); chk("bounce_1", activeRow, 4'b0000);
    run_until(t + 5); chk("bounce_2", activeRow, 4'b0001);
    run_until(t + 6); chk("bounce_3", activeRow, 4'b0000);
    run_until(t + 7); chk("bounce_hold_first", activeRow, 4'b0001);
    run_until(t + 22); chk("bounce_hold_last", activeRow, 4'b0001);
    run_until(t + 23); chk("bounce_released", activeRow, 4'b0000);
    run_until(last_end + 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Device-side model of a 3x4 matrix keypad: accepts queued key codes over a valid/ready handshake and "presses" each key for a programmed time.
- While a key is pressed, drives the row line for that key whenever the scanner drives that key's column.
- Sits opposite a column-driving keypad scanner in loopback/self-test builds and in automated keypad-entry paths.

Parameters:
- HOLD_CYCLES, 16, clock cycles contact is held closed per key (>=1).
- RELEASE_CYCLES, 8, clock cycles contact is open between keys (>=1).
- DEPTH_LOG2, 2, key FIFO depth = 2**DEPTH_LOG2.
- BOUNCE_CYCLES, 4, length of emulated contact bounce (used only with the optional feature).

Ports:
- clock  input  1  rising-edge clock; activeColumn is synchronous to it.
- resetN  input  1  asynchronous, active-low reset.
- keyCode  input  4  0-9 = digits, 10 = '*', 11 = '#', 12-15 invalid.
- keyValid  input  1  keyCode is valid.
- keyReady  output  1  FIFO not full.
- activeColumn  input  3  scanner column drive; bit0 = col1 (3,6,9,#), bit1 = col2 (2,5,8,0), bit2 = col3 (1,4,7,*).
- activeRow  output  4  emulated row sense; bit3 = row4 (1,2,3), bit2 = row3 (4,5,6), bit1 = row2 (7,8,9), bit0 = row1 (*,0,#).
- busy  output  1  state != IDLE or FIFO non-empty.
- keyDropped  output  1  one-cycle pulse: accepted code was invalid.

Behaviour:
- Reset (asynchronous): activeRow=0, keyDropped=0, busy=0, keyReady=1, FIFO empty, state IDLE, counters 0.
- Handshake: accept when keyValid && keyReady. Codes 0-11 are written to the FIFO. Codes 12-15 are not written; keyDropped pulses in the following cycle.
- keyReady = !full. No write occurs while full. No bypass path: an empty-FIFO write is popped no earlier than the next cycle.
- FSM states: IDLE, PRESS, RELEASE.
  - IDLE: if FIFO non-empty, pop into curKey and go to PRESS; load counter with HOLD_CYCLES-1.
  - PRESS: contact closed; count down. At 0, load RELEASE_CYCLES-1 and go to RELEASE.
  - RELEASE: contact open; count down. At 0, if FIFO non-empty, pop and go to PRESS directly; otherwise go to IDLE.
- Press duration: PRESS lasts exactly HOLD_CYCLES cycles and RELEASE exactly RELEASE_CYCLES cycles.
- Row output is registered:
  - activeRow <= (contact closed && activeColumn[col(curKey)]) ? rowbit(curKey) : 0.
  - Any activeColumn pattern is accepted, including zero or multi-hot; only the key's column bit matters.
  - Exactly one activeRow bit is ever high.
- Latency: key accepted in cycle T to an empty FIFO in IDLE → state PRESS from T+2 → activeRow reflects the key from T+3 (if its column is driven). Last PRESS cycle affects activeRow one cycle later; activeRow is 0 one cycle after RELEASE entry.
- FIFO pointers are DEPTH_LOG2+1 bits wide and wrap modulo 2·depth. Full = MSBs differ and lower bits equal.
- Simultaneous push and pop on a non-full FIFO both take effect; the count is unchanged.
- Reset mid-press: activeRow drops to 0 asynchronously and queued keys are discarded.

Optional Feature:
- Macro: KEYPAD_EMULATOR_BOUNCE_EN.
- Defined: a BOUNCE state is inserted before each PRESS, lasting BOUNCE_CYCLES cycles. In BOUNCE the contact starts closed and toggles every cycle (closed, open, closed, ...). BOUNCE then enters PRESS with the full HOLD_CYCLES. Total key time = BOUNCE_CYCLES + HOLD_CYCLES.
- Not defined: no BOUNCE state exists; BOUNCE_CYCLES is ignored.

Test Plan:
- Reset release, keyCode=5 accepted at T, activeColumn=3'b010 held → activeRow=4'b0100 from T+3 for 16 cycles, then 0 for ≥8 cycles; busy falls after RELEASE.
- Push 1, 2, #, * back-to-back with activeColumn toggling 001/010/100 → activeRow=1000 only with col3, 1000 only with col2, 0001 only with col1, 0001 only with col3; gaps of 8 cycles between keys.
- Push 4 codes with depth 4 while first is pressing → keyReady=0 after FIFO fills, a 5th keyValid is held off, keyReady=1 again the cycle after the next pop.
- keyCode=13 accepted → keyDropped=1 for one cycle, busy stays 0, activeRow stays 0.
- Assert resetN=0 mid-PRESS of key 9 with col1 driven → activeRow=0 immediately; after release busy=0 and FIFO empty.
- With KEYPAD_EMULATOR_BOUNCE_EN, key 0, col2 driven, BOUNCE_CYCLES=4 → activeRow=0001,0000,0001,0000, then 0001 for 16 cycles.
